// File: rtl/apb_cmd_master.sv
// APB requester: queues valid/ready commands in a DEPTH-entry FIFO and runs each one as a SETUP/ACCESS transfer.
// Latency: SETUP one edge after acceptance; response 3 edges later (4 for reads with RDATA_LAT=1).
// Backpressure: req_ready = !full; a response is held until rsp_ready. Define APB_TIMEOUT_EN to enable the ACCESS timeout.
module apb_cmd_master #(
    parameter int DW        = 32,
    parameter int AW        = 12,
    parameter int DEPTH     = 2,
    parameter int RDATA_LAT = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_RESP
    } state_t;

    localparam int PW = $clog2(DEPTH);

    cmd_t          fifo_q [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push, pop, full, empty;

    state_t        state_q;
    logic          psel_q, penable_q, pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
`endif

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state_q == S_IDLE) && !empty;
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; only pointers and count do.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= head.write;
                        paddr_q  <= head.addr;
                        pwdata_q <= head.write ? head.wdata : '0;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rsp_err_q <= PSLVERR;
                        if (pwrite_q) begin
                            rsp_rdata_q <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (RDATA_LAT == 0) begin
                            rsp_rdata_q <= PRDATA;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_CAPTURE;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    // Abandon the slave; any later PREADY lands outside ACCESS and is ignored.
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_CAPTURE: begin
                    rsp_rdata_q <= PRDATA;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: registered-output memory slave model plus a response scoreboard.
module tb_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   fails     = 0;
    int   rsp_seen  = 0;

    int   wait_states = 0;
    bit   stuck  = 1'b0;
    bit   err_en = 1'b0;
    int   acc_cnt;
    logic [31:0] mem [1024];
    logic [31:0] prdata_q;

    apb_cmd_master dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave with registered read data: PRDATA is valid one edge after the completing ACCESS edge.
    assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_states);
    assign PSLVERR = PREADY && err_en;
    assign PRDATA  = prdata_q;

    always @(posedge PCLK) begin
        if (!PRESETn) begin
            acc_cnt  <= 0;
            prdata_q <= 32'hDEAD_BEEF;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY) begin
                if (PWRITE) mem[PADDR[11:2]] <= PWDATA;
                else        prdata_q <= mem[PADDR[11:2]];
            end
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn && rsp_valid && rsp_ready) begin
            tests_run++;
            rsp_seen++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
                    fails++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Presents one command; returns #1 after the edge that accepted it.
    task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee);
        bit acc = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge PCLK);
            if (req_ready) begin
                acc = 1'b1;
                exp_q.push_back('{rdata: er, err: ee});
            end
            @(posedge PCLK); #1;
        end
        req_valid = 1'b0;
        tests_run++;
        if (!acc) begin
            fails++;
            $display("FAIL send_accept addr=%h: got not accepted, required accepted within 100 cycles", a);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        #3 PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        tests_run++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl: got %b, required 000", {PSEL, PENABLE, PWRITE});
        end
        tests_run++;
        if (PADDR !== 12'h0 || PWDATA !== 32'h0) begin
            fails++; $display("FAIL reset_bus: got PADDR=%h PWDATA=%h, required 0", PADDR, PWDATA);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL reset_rsp: got v=%b d=%h e=%b, required 0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(negedge PCLK);
        tests_run++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_single_write();
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        send(1'b1, 12'h004, 32'hA5A5_0001, 32'h0, 1'b0);
        @(negedge PCLK);
        tests_run++;
        if (PSEL !== 1'b0) begin
            fails++; $display("FAIL wr_early_psel: got %b, required 0", PSEL);
        end
        @(negedge PCLK);
        tests_run++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PADDR !== 12'h004 || PWDATA !== 32'hA5A5_0001) begin
            fails++; $display("FAIL wr_setup: got sel=%b en=%b wr=%b a=%h d=%h, required 1 0 1 004 a5a50001",
                              PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        tests_run++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL wr_access: got sel=%b en=%b rv=%b, required 1 1 0", PSEL, PENABLE, rsp_valid);
        end
        @(negedge PCLK);
        tests_run++;
        if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            fails++; $display("FAIL wr_resp: got rv=%b sel=%b en=%b, required 1 0 0", rsp_valid, PSEL, PENABLE);
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL wr_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_read_lat();
        @(posedge PCLK); #1;
        send(1'b0, 12'h004, 32'hFFFF_FFFF, 32'hA5A5_0001, 1'b0);
        @(negedge PCLK);
        @(negedge PCLK);
        tests_run++;
        if (PSEL !== 1'b1 || PWRITE !== 1'b0 || PADDR !== 12'h004 || PWDATA !== 32'h0) begin
            fails++; $display("FAIL rd_setup: got sel=%b wr=%b a=%h d=%h, required 1 0 004 0",
                              PSEL, PWRITE, PADDR, PWDATA);
        end
        @(negedge PCLK);
        @(negedge PCLK);
        tests_run++;
        if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
            fails++; $display("FAIL rd_capture: got rv=%b sel=%b, required 0 0", rsp_valid, PSEL);
        end
        @(negedge PCLK);
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            fails++; $display("FAIL rd_resp_t4: got rv=%b, required 1", rsp_valid);
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL rd_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int  seen0;
        bit  rdy_hi = 1'b0;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        send(1'b1, 12'h010, 32'h0000_1111, 32'h0, 1'b0);
        send(1'b1, 12'h014, 32'h0000_2222, 32'h0, 1'b0);
        send(1'b1, 12'h018, 32'h0000_3333, 32'h0, 1'b0);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge PCLK);
        @(posedge PCLK); #1;
        seen0 = rsp_seen;
        rsp_ready = 1'b0;
        send(1'b0, 12'h010, 32'h0, 32'h0000_1111, 1'b0);
        send(1'b0, 12'h014, 32'h0, 32'h0000_2222, 1'b0);
        send(1'b0, 12'h018, 32'h0, 32'h0000_3333, 1'b0);
        @(negedge PCLK);
        tests_run++;
        if (req_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_full: got req_ready=%b, required 0", req_ready);
        end
        @(posedge PCLK); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h01C; req_wdata = 32'h0000_4444;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (req_ready) rdy_hi = 1'b1;
        end
        tests_run++;
        if (rdy_hi) begin
            fails++; $display("FAIL b2b_hold: got req_ready=1 while full, required 0");
        end
        @(posedge PCLK); #1 rsp_ready = 1'b1;
        send(1'b1, 12'h01C, 32'h0000_4444, 32'h0, 1'b0);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0 || rsp_seen - seen0 != 4) begin
            fails++; $display("FAIL b2b_count: got %0d responses %0d pending, required 4 and 0",
                              rsp_seen - seen0, exp_q.size());
        end
    endtask

    task automatic test_wait_err();
        int n = 0;
        bit bad = 1'b0;
        wait_states = 5; err_en = 1'b1; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        send(1'b1, 12'h030, 32'h5555_AAAA, 32'h0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                n++;
                if (PADDR !== 12'h030 || PWRITE !== 1'b1 || PWDATA !== 32'h5555_AAAA) bad = 1'b1;
            end else if (n > 0) begin
                break;
            end
        end
        tests_run++;
        if (n != 6 || bad) begin
            fails++; $display("FAIL wait_access: got %0d access cycles unstable=%b, required 6 stable", n, bad);
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL wait_drain: got %0d pending, required 0", exp_q.size());
        end
        wait_states = 0; err_en = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
        send(1'b0, 12'h004, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) n++;
            else if (n > 0) break;
        end
        tests_run++;
        if (n != 16) begin
            fails++; $display("FAIL tmo_cycles: got %0d access cycles, required 16", n);
        end
        stuck = 1'b0;
        send(1'b0, 12'h010, 32'h0, 32'h0000_1111, 1'b0);
`else
        send(1'b0, 12'h004, 32'h0, 32'hA5A5_0001, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) n++;
        end
        tests_run++;
        if (n != 28 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL nowait_cycles: got %0d access cycles rv=%b, required 28 and 0", n, rsp_valid);
        end
        @(posedge PCLK); #1 stuck = 1'b0;
`endif
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL tmo_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit act  = 1'b0;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        stuck = 1'b1;
        send(1'b1, 12'h040, 32'h0000_0077, 32'h0, 1'b0);
        send(1'b0, 12'h010, 32'h0, 32'h0000_1111, 1'b0);
        for (int i = 0; i < 20 && !act; i++) begin
            @(negedge PCLK);
            act = PSEL && PENABLE;
        end
        #2 PRESETn = 1'b0;
        #1;
        tests_run++;
        if (!act || {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0 || PADDR !== 12'h0 ||
            PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL mid_reset: got act=%b sel=%b en=%b wr=%b a=%h d=%h rv=%b rdy=%b, required act=1 all 0 rdy=1",
                              act, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req_ready);
        end
        exp_q.delete();
        @(posedge PCLK); #1 stuck = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            fails++; $display("FAIL mid_reset_quiet: got activity after reset, required none");
        end
        @(posedge PCLK); #1;
        send(1'b0, 12'h014, 32'h0, 32'h0000_2222, 1'b0);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge PCLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL post_reset_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_lat();
        test_back_to_back();
        test_wait_err();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge PCLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
